// File: rtl/matmul_operand_loader_if.sv
// Host-side bus for matmul_operand_loader: run control, operand byte stream,
// A/B operand RAM write ports and the start/done/clear handshake with the core.
interface matmul_operand_loader_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 11
);
  logic              go;
  logic [AWIDTH-1:0] base_a;
  logic [AWIDTH-1:0] base_b;
  logic [7:0]        stride_a;
  logic [7:0]        stride_b;
  logic              s_valid;
  logic [DWIDTH-1:0] s_data;
  logic              s_ready;
  logic              a_we;
  logic [AWIDTH-1:0] a_addr;
  logic [DWIDTH-1:0] a_data;
  logic              b_we;
  logic [AWIDTH-1:0] b_addr;
  logic [DWIDTH-1:0] b_data;
  logic              start_reg;
  logic              clear_done_reg;
  logic              done_mat_mul;
  logic              busy;
  logic              op_done;

  modport master (
    output go, base_a, base_b, stride_a, stride_b, s_valid, s_data, done_mat_mul,
    input  s_ready, a_we, a_addr, a_data, b_we, b_addr, b_data,
           start_reg, clear_done_reg, busy, op_done
  );

  modport slave (
    input  go, base_a, base_b, stride_a, stride_b, s_valid, s_data, done_mat_mul,
    output s_ready, a_we, a_addr, a_data, b_we, b_addr, b_data,
           start_reg, clear_done_reg, busy, op_done
  );
endinterface

// File: rtl/matmul_operand_loader.sv
// Streams A and B into the operand RAMs (A column-contiguous, B row-contiguous),
// then sequences the core. Define MATMUL_LOADER_ZERO_TAIL_EN to zero the RAM tail.
module matmul_operand_loader #(
  parameter int MAT_DIM   = 4,
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 11,
  parameter int MEM_DEPTH = 2048
) (
  input  logic                    clk,
  input  logic                    reset,
  matmul_operand_loader_if.slave  bus
);
  localparam int                CW        = (MAT_DIM > 1) ? $clog2(MAT_DIM) : 1;
  localparam logic [CW-1:0]     LAST      = CW'(MAT_DIM - 1);
  localparam logic [AWIDTH-1:0] TAIL_BASE = AWIDTH'(MEM_DEPTH - 4);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, ZERO_TAIL, START, WAIT_DONE, CLEAR
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     r, c;
  logic [1:0]        k;
  logic [AWIDTH-1:0] base_a_q, base_b_q;
  logic [7:0]        stride_a_q, stride_b_q;
  logic              latch, acc_a, acc_b, tail_wr, set_start, set_clear, fin;
  logic              last_beat;
  logic [AWIDTH-1:0] addr_a, addr_b, tail_addr;
  logic [DWIDTH-1:0] wr_data;

  assign wr_data   = bus.s_data;
  assign last_beat = (r == LAST) && (c == LAST);
  // All address math is AWIDTH wide so out-of-range bases wrap modulo the RAM.
  assign addr_a    = base_a_q + AWIDTH'(c) * AWIDTH'(stride_a_q) + AWIDTH'(r);
  assign addr_b    = base_b_q + AWIDTH'(r) * AWIDTH'(stride_b_q) + AWIDTH'(c);
  assign tail_addr = TAIL_BASE + AWIDTH'(k);

  assign bus.busy    = (state != IDLE);
  assign bus.s_ready = (state == LOAD_A) || (state == LOAD_B);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    latch     = 1'b0;
    acc_a     = 1'b0;
    acc_b     = 1'b0;
    tail_wr   = 1'b0;
    set_start = 1'b0;
    set_clear = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: if (bus.go) begin
        latch   = 1'b1;
        state_n = LOAD_A;
      end
      LOAD_A: if (bus.s_valid) begin
        acc_a = 1'b1;
        if (last_beat) state_n = LOAD_B;
      end
      LOAD_B: if (bus.s_valid) begin
        acc_b = 1'b1;
`ifdef MATMUL_LOADER_ZERO_TAIL_EN
        if (last_beat) state_n = ZERO_TAIL;
`else
        if (last_beat) state_n = START;
`endif
      end
      ZERO_TAIL: begin
        tail_wr = 1'b1;
        if (k == 2'd3) state_n = START;
      end
      START: begin
        set_start = 1'b1;
        state_n   = WAIT_DONE;
      end
      WAIT_DONE: if (bus.done_mat_mul) begin
        set_clear = 1'b1;
        state_n   = CLEAR;
      end
      CLEAR: if (!bus.done_mat_mul) begin
        fin     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r                  <= '0;
      c                  <= '0;
      k                  <= '0;
      base_a_q           <= '0;
      base_b_q           <= '0;
      stride_a_q         <= '0;
      stride_b_q         <= '0;
      bus.a_we           <= 1'b0;
      bus.a_addr         <= '0;
      bus.a_data         <= '0;
      bus.b_we           <= 1'b0;
      bus.b_addr         <= '0;
      bus.b_data         <= '0;
      bus.start_reg      <= 1'b0;
      bus.clear_done_reg <= 1'b0;
      bus.op_done        <= 1'b0;
    end else begin
      if (latch) begin
        base_a_q   <= bus.base_a;
        base_b_q   <= bus.base_b;
        stride_a_q <= bus.stride_a;
        stride_b_q <= bus.stride_b;
      end
      // Row-major walk; wrapping r after the last beat re-arms the counters for B.
      if (latch) begin
        r <= '0;
        c <= '0;
        k <= '0;
      end else begin
        if (acc_a || acc_b) begin
          if (c == LAST) begin
            c <= '0;
            r <= (r == LAST) ? '0 : r + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
        if (tail_wr) k <= k + 2'd1;
      end
      bus.a_we   <= acc_a || tail_wr;
      bus.a_addr <= tail_wr ? tail_addr : addr_a;
      bus.a_data <= acc_a ? wr_data : '0;
      bus.b_we   <= acc_b || tail_wr;
      bus.b_addr <= tail_wr ? tail_addr : addr_b;
      bus.b_data <= acc_b ? wr_data : '0;
      if (set_start)      bus.start_reg <= 1'b1;
      else if (set_clear) bus.start_reg <= 1'b0;
      if (set_clear)      bus.clear_done_reg <= 1'b1;
      else if (fin)       bus.clear_done_reg <= 1'b0;
      bus.op_done <= fin;
    end
  end
endmodule

// File: doc/matmul_operand_loader.md
# matmul_operand_loader

Host-side loader and run sequencer for `matrix_multiplication`. It accepts matrix A and matrix B as one row-major byte stream and writes each element into the A and B operand RAM write ports in the layout the systolic core reads: A column-contiguous, B row-contiguous. It also zeroes the RAM tail, then runs the `start_reg` / `done_mat_mul` / `clear_done_reg` handshake. It sits between the host/DMA interface and the core, so benches no longer need to `force` RAM contents.

## Interface
- `MAT_DIM`, 4, matrix dimension N (A and B are N×N)
- `DWIDTH`, 8, element width
- `AWIDTH`, 11, RAM address width (matches `address_mat_a`)
- `MEM_DEPTH`, 2048, RAM depth in words; tail addresses are MEM_DEPTH-4 … MEM_DEPTH-1
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `go`  in  1  start pulse; sampled only in IDLE
- `base_a`, `base_b`  in  AWIDTH  base address of A / B; sampled on accepted `go`
- `stride_a`, `stride_b`  in  8  address stride between columns of A / rows of B; sampled on accepted `go`
- `s_valid`  in  1  stream beat valid
- `s_data`  in  DWIDTH  stream element; A first, then B, both row-major
- `s_ready`  out  1  loader accepts a beat
- `a_we`, `a_addr`, `a_data`  out  1/AWIDTH/DWIDTH  matrix A RAM write port
- `b_we`, `b_addr`, `b_data`  out  1/AWIDTH/DWIDTH  matrix B RAM write port
- `start_reg`  out  1  start request to the core
- `clear_done_reg`  out  1  done-clear request to the core
- `done_mat_mul`  in  1  core completion flag
- `busy`  out  1  high whenever state ≠ IDLE
- `op_done`  out  1  one-cycle pulse when the sequence finishes

## Operation
- States: IDLE → LOAD_A → LOAD_B → ZERO_TAIL → START → WAIT_DONE → CLEAR → IDLE.
- IDLE: `go` high latches bases and strides, clears row/col counters r and c, and moves to LOAD_A. `go` in any other state is ignored.
- LOAD_A / LOAD_B: `s_ready`=1. A beat is accepted when `s_valid & s_ready`.
  - Beats fill r,c in row-major order; c increments, wraps at MAT_DIM-1, then r increments.
  - Accepted A beat: `a_addr` = base_a + c*stride_a + r.
  - Accepted B beat: `b_addr` = base_b + r*stride_b + c.
  - Address arithmetic is AWIDTH bits, modulo 2^AWIDTH; overflow wraps silently.
  - With `s_valid` low, no write occurs and the counters hold.
  - After beat N²-1 of A, counters clear and the state moves to LOAD_B.
  - After beat N²-1 of B, the state moves to ZERO_TAIL.
- ZERO_TAIL: for 4 cycles, writes 0 to MEM_DEPTH-4+k (k=0..3) on both ports at once, then moves to START.
- START: `start_reg`=1. The next cycle moves to WAIT_DONE, with `start_reg` held at 1.
- WAIT_DONE: `start_reg` stays 1 until `done_mat_mul` is sampled high. Then `start_reg`→0, `clear_done_reg`→1, state→CLEAR.
- CLEAR: `clear_done_reg` stays 1 until `done_mat_mul` is sampled low. Then `clear_done_reg`→0, `op_done` pulses, state→IDLE.
- `done_mat_mul` is ignored outside WAIT_DONE and CLEAR.
- `s_ready`=0 outside the LOAD states.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Reset asserted mid-sequence aborts immediately; no further writes are issued and `start_reg` drops asynchronously.
- Write ports are registered: an accepted beat at edge t appears on `we`/`addr`/`data` during cycle t+1, for exactly one cycle per beat.
- A `go` at edge 0 followed by continuous `s_valid` gives:
  - A writes in cycles 2..N²+1
  - B writes in cycles N²+2..2N²+1
  - tail writes in cycles 2N²+2..2N²+5
  - `start_reg` rising in cycle 2N²+6
- A→B transition has no bubble: the beat after A's last beat is accepted as B[0][0].
- `op_done` is high for exactly one cycle, coincident with `busy` falling.

## Configuration
- `MATMUL_LOADER_ZERO_TAIL_EN`:
  - Defined: ZERO_TAIL state present as described.
  - Undefined: ZERO_TAIL is skipped; LOAD_B's last beat goes directly to START (`start_reg` rises in cycle 2N²+2), and no tail writes are issued.

## Test plan
- Reset, then `go` with base_a=0, stride_a=4; stream A rows 8 4 6 8 / 3 3 3 7 / 5 2 1 6 / 9 1 0 5 → A writes (addr,data) (0,8),(4,4),(8,6),(12,8),(1,3),…,(15,5); RAM[0..3]=8,3,5,9.
- Same run, B rows 1 1 3 0 / 0 1 4 3 / 3 5 3 1 / 9 6 3 2, base_b=0, stride_b=4 → B write i goes to addr i with data B row-major; then tail writes 0 to 2044..2047 on both ports; the core drives C = 98 90 82 34 / … / 54 40 46 13.
- `s_valid` toggled 1/0 every cycle during loading → exactly 32 data writes, no duplicates; `start_reg` rises 2 cycles after the 32nd write is complete and the tail is written.
- Handshake: `done_mat_mul` asserted 10 cycles after `start_reg` → `start_reg` falls next cycle and `clear_done_reg`=1; `done_mat_mul` dropped → `clear_done_reg`=0 and one `op_done` pulse; `go` pulses during busy are ignored.
- `reset` asserted at the 7th A beat → all outputs 0 immediately; a new `go` restarts at A[0][0] at address base_a.
- base_a=2046, stride_a=4 → addresses wrap modulo 2048 (A[1][0] goes to 2047, A[2][0] to 0).
